// File: rtl/secded_decoder.sv
// Two-stage SECDED (39,32) decoder: corrects single-bit errors, flags double/multi-bit errors,
// and keeps saturating SEC/DED event counters. Stage 1 holds code+syndrome, stage 2 the result.
module secded_decoder #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [38:0]      in_code,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic             out_sec,
    output logic             out_ded,
    output logic [5:0]       out_syndrome,
    input  logic             clr_cnt,
    output logic [CNT_W-1:0] sec_cnt,
    output logic [CNT_W-1:0] ded_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             w_adv;
    logic [5:0]       w_syn;
    logic             w_par;
    logic             w_in_range;
    logic             w_sec;
    logic             w_ded;
    logic [38:0]      w_fix;
    logic [31:0]      w_data;

    logic             r_s1_valid;
    logic [38:0]      r_s1_code;
    logic [5:0]       r_s1_syn;
    logic             r_s1_par;
    logic             r_out_valid;
    logic [31:0]      r_out_data;
    logic             r_out_sec;
    logic             r_out_ded;
    logic [5:0]       r_out_syn;
    logic [CNT_W-1:0] r_sec_cnt;
    logic [CNT_W-1:0] r_ded_cnt;

    // One global stall: both stages advance together or hold together.
    assign w_adv    = !r_out_valid || out_ready;
    assign in_ready = w_adv;

    // Bit 38 is the overall parity, so it never enters the Hamming syndrome.
    always_comb begin
        w_syn = '0;
        for (int j = 1; j <= 38; j++) begin
            for (int k = 0; k < 6; k++) begin
                if (((j >> k) & 1) == 1) begin
                    w_syn[k] = w_syn[k] ^ in_code[j-1];
                end
            end
        end
    end

    assign w_par = ^in_code;

    assign w_in_range = (r_s1_syn != 6'd0) && (r_s1_syn <= 6'd38);
    assign w_sec      = r_s1_par && ((r_s1_syn == 6'd0) || w_in_range);
    assign w_ded      = (r_s1_syn != 6'd0) && !(r_s1_par && w_in_range);

    always_comb begin
        w_fix = r_s1_code;
        if (r_s1_par && w_in_range) begin
            w_fix = r_s1_code ^ (39'd1 << (r_s1_syn - 6'd1));
        end
    end

    assign w_data = {w_fix[37:32], w_fix[30:16], w_fix[14:8], w_fix[6:4], w_fix[2]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid  <= 1'b0;
            r_s1_code   <= '0;
            r_s1_syn    <= '0;
            r_s1_par    <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sec   <= 1'b0;
            r_out_ded   <= 1'b0;
            r_out_syn   <= '0;
            r_sec_cnt   <= '0;
            r_ded_cnt   <= '0;
        end else begin
            if (w_adv) begin
                r_s1_valid  <= in_valid;
                r_s1_code   <= in_code;
                r_s1_syn    <= w_syn;
                r_s1_par    <= w_par;
                r_out_valid <= r_s1_valid;
                r_out_data  <= w_data;
                r_out_sec   <= w_sec;
                r_out_ded   <= w_ded;
                r_out_syn   <= r_s1_syn;
            end
            // Counting on the stage-2 load guarantees each accepted word is counted once.
            if (clr_cnt) begin
                r_sec_cnt <= '0;
                r_ded_cnt <= '0;
            end else begin
                if (w_adv && r_s1_valid && w_sec && (r_sec_cnt != CNT_MAX)) begin
                    r_sec_cnt <= r_sec_cnt + CNT_ONE;
                end
                if (w_adv && r_s1_valid && w_ded && (r_ded_cnt != CNT_MAX)) begin
                    r_ded_cnt <= r_ded_cnt + CNT_ONE;
                end
            end
        end
    end

    assign out_valid    = r_out_valid;
    assign out_data     = r_out_data;
    assign out_sec      = r_out_sec;
    assign out_ded      = r_out_ded;
    assign out_syndrome = r_out_syn;
    assign sec_cnt      = r_sec_cnt;
    assign ded_cnt      = r_ded_cnt;

endmodule

// File: tb/tb_secded_decoder.sv
// Bench for secded_decoder: directed vector table, random double flips, backpressure,
// counter clear/saturation and mid-flight reset. A CNT_W=4 twin shares the stimulus.
module tb_secded_decoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [38:0] in_code;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_sec;
    logic        out_ded;
    logic [5:0]  out_syndrome;
    logic        clr_cnt;
    logic [15:0] sec_cnt;
    logic [15:0] ded_cnt;

    logic        s_in_ready, s_out_valid, s_out_sec, s_out_ded;
    logic [31:0] s_out_data;
    logic [5:0]  s_out_syndrome;
    logic [3:0]  s_sec_cnt, s_ded_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    secded_decoder #(.CNT_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_code(in_code),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_sec(out_sec),
        .out_ded(out_ded), .out_syndrome(out_syndrome), .clr_cnt(clr_cnt),
        .sec_cnt(sec_cnt), .ded_cnt(ded_cnt)
    );

    secded_decoder #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready), .in_code(in_code),
        .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data), .out_sec(s_out_sec),
        .out_ded(s_out_ded), .out_syndrome(s_out_syndrome), .clr_cnt(clr_cnt),
        .sec_cnt(s_sec_cnt), .ded_cnt(s_ded_cnt)
    );

    typedef struct {
        logic [38:0] code;
        logic [31:0] data;
        logic        sec;
        logic        ded;
        logic [5:0]  syn;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [38:0] place(input logic [31:0] d);
        logic [38:0] c;
        c = '0;
        c[2]     = d[0];
        c[6:4]   = d[3:1];
        c[14:8]  = d[10:4];
        c[30:16] = d[25:11];
        c[37:32] = d[31:26];
        return c;
    endfunction

    function automatic logic [31:0] extract(input logic [38:0] c);
        return {c[37:32], c[30:16], c[14:8], c[6:4], c[2]};
    endfunction

    function automatic logic [38:0] encode(input logic [31:0] d);
        logic [38:0] c;
        logic        p;
        c = place(d);
        for (int k = 0; k < 6; k++) begin
            p = 1'b0;
            for (int j = 1; j <= 38; j++) begin
                if (((j >> k) & 1) == 1) p = p ^ c[j-1];
            end
            c[(1 << k) - 1] = p;
        end
        c[38] = ^c[37:0];
        return c;
    endfunction

    function automatic logic [63:0] pack_out(input logic v, input logic s, input logic d,
                                             input logic [5:0] syn, input logic [31:0] data);
        return {23'd0, v, s, d, syn, data};
    endfunction

    // Streams the queued vectors back to back with out_ready high; result t shows up two edges later.
    task automatic run_vecs(input string name);
        for (int t = 0; t <= vecs.size(); t++) begin
            if (t < vecs.size()) begin
                in_valid = 1'b1;
                in_code  = vecs[t].code;
            end else begin
                in_valid = 1'b0;
                in_code  = '0;
            end
            step();
            if (t >= 1) begin
                check($sformatf("%s[%0d]", name, t - 1),
                      pack_out(out_valid, out_sec, out_ded, out_syndrome, out_data),
                      pack_out(1'b1, vecs[t-1].sec, vecs[t-1].ded, vecs[t-1].syn, vecs[t-1].data));
            end
        end
        step();
        check({name, "_drain"}, {63'd0, out_valid}, 64'd0);
    endtask

    localparam logic [31:0] D_A5 = 32'hA5A5_5A5A;

    initial begin
        logic [38:0] c;
        logic [38:0] base;
        int          a, b;
        vec_t        v;
        logic [31:0] exp_q[$];
        logic [63:0] prev_out;
        logic        prev_stall;
        logic        stall;
        int          sent, recv, cyc;
        logic [3:0]  pat;

        rst = 1'b1; in_valid = 1'b0; in_code = '0; out_ready = 1'b0; clr_cnt = 1'b0;
        step(); step();
        check("reset_out", pack_out(out_valid, out_sec, out_ded, out_syndrome, out_data), 64'd0);
        check("reset_cnt", {32'd0, sec_cnt, ded_cnt}, 64'd0);
        rst = 1'b0;
        #1;
        check("reset_in_ready", {63'd0, in_ready}, 64'd1);
        out_ready = 1'b1;

        // Directed table: clean, double, out-of-range multi-bit, clean encoded, single-error sweep.
        vecs.delete();
        v.code = '0; v.data = 32'h0; v.sec = 0; v.ded = 0; v.syn = 6'd0; vecs.push_back(v);
        c = '0; c[2] = 1'b1; c[4] = 1'b1;
        v.code = c; v.data = 32'h3; v.sec = 0; v.ded = 1; v.syn = 6'd6; vecs.push_back(v);
        c = '0; c[0] = 1'b1; c[7] = 1'b1; c[31] = 1'b1;
        v.code = c; v.data = 32'h0; v.sec = 0; v.ded = 1; v.syn = 6'd41; vecs.push_back(v);
        base = encode(D_A5);
        v.code = base; v.data = D_A5; v.sec = 0; v.ded = 0; v.syn = 6'd0; vecs.push_back(v);
        for (int i = 0; i <= 38; i++) begin
            c = base;
            c[i] = ~c[i];
            v.code = c; v.data = D_A5; v.sec = 1; v.ded = 0;
            v.syn = (i == 38) ? 6'd0 : 6'(i + 1);
            vecs.push_back(v);
        end
        run_vecs("directed");
        check("sec_cnt_sweep", {48'd0, sec_cnt}, 64'd39);
        check("ded_cnt_directed", {48'd0, ded_cnt}, 64'd2);

        // Random double flips: syndrome is the XOR of positions (bit 38 contributes nothing).
        vecs.delete();
        for (int n = 0; n < 1000; n++) begin
            base = encode($urandom());
            a = $urandom_range(0, 38);
            b = $urandom_range(0, 37);
            if (b >= a) b = b + 1;
            c = base;
            c[a] = ~c[a];
            c[b] = ~c[b];
            v.code = c;
            v.data = extract(c);
            v.sec  = 0;
            v.ded  = 1;
            v.syn  = ((a == 38) ? 6'd0 : 6'(a + 1)) ^ ((b == 38) ? 6'd0 : 6'(b + 1));
            vecs.push_back(v);
        end
        run_vecs("double");
        check("ded_cnt_after_random", {48'd0, ded_cnt}, 64'd1002);
        check("ded_cnt4_saturated", {60'd0, s_ded_cnt}, 64'd15);
        check("sec_cnt4_saturated", {60'd0, s_sec_cnt}, 64'd15);

        // clr_cnt lands on the same edge that loads an SEC result.
        c = encode(32'h1234_5678);
        c[10] = ~c[10];
        in_valid = 1'b1; in_code = c;
        step();
        in_valid = 1'b0; clr_cnt = 1'b1;
        step();
        clr_cnt = 1'b0;
        check("clr_word_sec", {62'd0, out_valid, out_sec}, 64'd3);
        check("clr_sec_cnt", {48'd0, sec_cnt}, 64'd0);
        check("clr_ded_cnt4", {60'd0, s_ded_cnt}, 64'd0);
        step();
        check("clr_sec_cnt_hold", {48'd0, sec_cnt}, 64'd0);

        // Reset with one word in stage 1 and another presented.
        in_valid = 1'b1; in_code = c;
        step();
        check("pre_rst_sec_cnt", {48'd0, sec_cnt}, 64'd0);
        in_code = encode(32'hDEAD_BEEF) ^ 39'd1;
        rst = 1'b1;
        step();
        rst = 1'b0; in_valid = 1'b0;
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_cnt", {32'd0, sec_cnt, ded_cnt}, 64'd0);
        step(); step();
        check("rst_dropped", {47'd0, out_valid, sec_cnt}, 64'd0);

        // Backpressure: out_ready follows 1-0-0-1, scoreboard checks order and stability.
        pat = 4'b1001;
        sent = 0; recv = 0; cyc = 0; prev_stall = 1'b0; prev_out = '0;
        while (recv < 8 && cyc < 200) begin
            out_ready = pat[3 - (cyc % 4)];
            if (sent < 8) begin
                c = encode(32'h1000_0000 + 32'h0101_0101 * sent);
                c[sent * 4] = ~c[sent * 4];
                in_valid = 1'b1;
                in_code  = c;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (prev_stall) begin
                check("bp_stable", pack_out(out_valid, out_sec, out_ded, out_syndrome, out_data),
                      prev_out);
            end
            stall = out_valid && !out_ready;
            if (stall) check("bp_in_ready_low", {63'd0, in_ready}, 64'd0);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("bp_unexpected", {32'd0, out_data}, 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    check($sformatf("bp_word[%0d]", recv), {31'd0, out_sec, out_data},
                          {31'd0, 1'b1, exp_q.pop_front()});
                end
                recv++;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(32'h1000_0000 + 32'h0101_0101 * sent);
                sent++;
            end
            prev_stall = stall;
            prev_out   = pack_out(out_valid, out_sec, out_ded, out_syndrome, out_data);
            step();
            cyc++;
        end
        check("bp_received", recv, 64'd8);
        out_ready = 1'b1; in_valid = 1'b0;
        step(); step();
        check("bp_no_extra", {63'd0, out_valid}, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/secded_decoder.md
# secded_decoder

Pipelined SECDED (39,32) decoder that is the receive-side counterpart of the SECDED encoder. It accepts 39-bit codewords in the encoder's bit layout, corrects any single-bit error, detects double-bit errors and flags them, and returns 32-bit data. It sits between protected storage or a TMR voter path and the consumer. It uses a valid/ready handshake on both sides, two register stages and saturating error counters.

## Interface
- CNT_W, default 16, width of the SEC and DED event counters.
- clk  input  1  clock; all logic is on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  codeword on in_code is valid.
- in_ready  output  1  decoder accepts in_code this cycle.
- in_code  input  39  codeword in encoder layout.
- out_valid  output  1  result on out_* is valid.
- out_ready  input  1  consumer accepts the result.
- out_data  output  32  corrected data (uncorrected if out_ded).
- out_sec  output  1  a single error was corrected (includes an error in the overall-parity bit).
- out_ded  output  1  the error is uncorrectable (double or multi-bit).
- out_syndrome  output  6  Hamming syndrome of the word.
- clr_cnt  input  1  synchronous clear of both counters.
- sec_cnt  output  CNT_W  saturating count of SEC results.
- ded_cnt  output  CNT_W  saturating count of DED results.

## Operation
- Codeword layout (index = Hamming position − 1):
  - Parity bits at indices 0, 1, 3, 7, 15, 31.
  - Overall parity at index 38.
  - Data at the remaining indices: data[0]→2, data[3:1]→6:4, data[10:4]→14:8, data[25:11]→30:16, data[31:26]→37:32.
- Syndrome bit k (k=0..5) is the XOR of in_code[j−1] for all j in 1..38 where bit k of j is 1. Index 38 is excluded, because the encoder computed Hamming parity with bit 38 at 0.
- Overall check p is the XOR of all 39 bits.
- Classification:
  - s=0, p=0: clean; sec=0, ded=0.
  - s=0, p=1: the error is in bit 38; data unchanged; sec=1.
  - s in 1..38, p=1: flip code[s−1], then extract data; sec=1.
  - s in 39..63, p=1: ded=1; data extracted uncorrected.
  - s≠0, p=0: ded=1; data extracted uncorrected.
- sec and ded are never both 1.
- Pipeline:
  - Stage 1 registers code, s and p.
  - Stage 2 registers corrected data, flags and syndrome onto out_*.
- Counters:
  - sec_cnt and ded_cnt increment by 1 when stage 2 loads a valid word with the corresponding flag set.
  - Both counters saturate at 2^CNT_W−1.
  - clr_cnt has priority over an increment in the same cycle.

## Timing
- Reset values: out_valid=0, out_data=0, out_sec=0, out_ded=0, out_syndrome=0, sec_cnt=0, ded_cnt=0, and stage-1 valid=0.
- in_ready=1 in the cycle after reset.
- Global stall: adv = !out_valid || out_ready, and in_ready = adv.
  - When adv=1, both stages shift: stage 1 takes the input, and stage 2 takes stage 1.
  - When adv=0, all pipeline registers hold.
- Latency: a word accepted in cycle N (in_valid && in_ready) appears on out_* in cycle N+2, provided out_ready stayed high.
- Throughput is one word per cycle.
- Holding rules:
  - While out_valid=1 and out_ready=0, out_* stay stable.
  - A bubble (in_valid=0 while adv=1) propagates as stage valid=0.
- Each accepted word loads stage 2 exactly once, so it is counted exactly once.
- in_ready does not depend on in_valid.
- in_ready combinationally depends on out_ready; that is the only combinational input-to-output path.
- Reset mid-operation clears both stages; in-flight words are dropped and not counted.
- rst has priority over clr_cnt and over the handshake.

## Test plan
- **Clean word:** in_code=0 → after 2 cycles out_data=0x00000000, sec=0, ded=0, syndrome=0.
- **Single error, sweep:** for each index 0..38, encode D=0xA5A5_5A5A with the golden model and flip that index → out_data=0xA5A55A5A, sec=1, ded=0. Syndrome is index+1 for indices 0..37 and 0 for index 38. sec_cnt ends at 39.
- **Double error:** in_code with only bits 2 and 4 set → syndrome=6, ded=1, sec=0, out_data=0x00000003. Over 1000 random double flips, ded is always 1.
- **Multi-bit, out-of-range syndrome:** in_code with bits 0, 7 and 31 set → syndrome=41, p=1, ded=1, out_data=0.
- **Backpressure:**
  - Stream 8 words with out_ready toggling in a 1-0-0-1 pattern → no word is lost or duplicated, order is preserved, and out_* are stable while stalled.
  - in_ready=0 whenever out_valid && !out_ready.
- **Counters and reset:**
  - Force ded_cnt to saturate with CNT_W=4 → it holds at 15.
  - Assert clr_cnt together with an SEC result → sec_cnt=0.
  - Assert rst with 2 words in flight → out_valid=0 next cycle and counters=0.
